seq_frame_serializer: RTL

- Upstream feeder for the Mealy sequence detector.
- Accepts parallel WIDTH-bit words over a valid/ready handshake and shifts them out LSB-first, one bit per clock, on a serial line that drives the detector's `in` input.
- Marks frame boundaries and counts completed frames.
- A one-entry pending buffer allows back-to-back frames with no idle gap on the serial line.

---
 rtl/seq_frame_serializer.sv | 96 +++++++++
 1 files changed

// File: rtl/seq_frame_serializer.sv
// seq_frame_serializer: LSB-first parallel-to-serial feeder with a one-word pending buffer
module seq_frame_serializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             last;

    assign data_ready  = !pend_full_q;
    assign accept      = data_valid & data_ready;
    assign out_valid   = state_q == SHIFT;
    assign last        = out_valid && idx_q == LAST;
    assign out_bit     = out_valid & shreg_q[0];
    assign frame_start = out_valid && idx_q == '0;
    assign frame_end   = last;
    assign busy        = out_valid | pend_full_q;
    assign frame_count = cnt_q;

    // Next state: load from idle, shift mid-frame, and on the last bit chain the
    // older pending word ahead of any new input so the line stays gap-free.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        if (state_q == IDLE) begin
            if (accept) begin
                shreg_d = data_in;
                idx_d   = '0;
                state_d = SHIFT;
            end
        end else if (last) begin
            cnt_d = cnt_q + 1'b1;
            idx_d = '0;
            if (pend_full_q) begin
                shreg_d     = pend_q;
                pend_full_d = 1'b0;
            end else if (accept) begin
                shreg_d = data_in;
            end else begin
                state_d = IDLE;
            end
        end else begin
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 1'b1;
            if (accept) begin
                pend_d      = data_in;
                pend_full_d = 1'b1;
            end
        end
    end

    // State registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule
